dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single data memory between the core load/store path and a loader/debug port, so programs and data can be written into memory while the core is held or running. Sits between the requesters and the data memory: forwards one granted request per cycle to the memory, captures read data and returns a registered one-cycle-late response to the winner. Core has fixed priority; a starvation counter guarantees the loader progress.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arb_prio.sv | 34 +++
 rtl/dmem_arbiter.sv | 88 ++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: width defaults, port ids and response types.
package dmem_arbiter_pkg;

  localparam int unsigned DefAW = 32;
  localparam int unsigned DefDW = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  typedef enum logic [1:0] {
    RespNone  = 2'd0,
    RespRead  = 2'd1,
    RespWrite = 2'd2
  } resp_type_e;

  function automatic resp_type_e resp_type(input logic gnt, input logic we);
    if (!gnt) return RespNone;
    return we ? RespWrite : RespRead;
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed core-priority grant with a starvation counter that forces a loader grant.
module dmem_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic c_valid_i,
  input  logic l_valid_i,
  output logic c_gnt_o,
  output logic l_gnt_o
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    l_gnt_o = l_valid_i && (!c_valid_i || (cnt_q == Limit));
    c_gnt_o = c_valid_i && !l_gnt_o;
    cnt_d   = cnt_q;
    // Neither valid: hold. Core alone or loader served: restart.
    if (l_gnt_o || (c_valid_i && !l_valid_i)) begin
      cnt_d = '0;
    end else if (c_gnt_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: forwards one granted request per cycle, returns a
// registered response to the winner one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW           = DefAW,
  parameter int unsigned DW           = DefDW,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req_valid,
  input  logic          c_req_we,
  input  logic [AW-1:0] c_req_addr,
  input  logic [DW-1:0] c_req_wdata,
  output logic          c_req_ready,
  output logic          c_resp_valid,
  input  logic          l_req_valid,
  input  logic          l_req_we,
  input  logic [AW-1:0] l_req_addr,
  input  logic [DW-1:0] l_req_wdata,
  output logic          l_req_ready,
  output logic          l_resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic       c_gnt, l_gnt;
  resp_type_e resp_type_q, resp_type_d;
  logic       win_q, win_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Requests are masked while in reset so ready and memory outputs stay quiet.
  dmem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .c_valid_i(c_req_valid & rst),
    .l_valid_i(l_req_valid & rst),
    .c_gnt_o  (c_gnt),
    .l_gnt_o  (l_gnt)
  );

  assign c_req_ready = c_gnt;
  assign l_req_ready = l_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_req_we;
      mem_addr  = c_req_addr;
      mem_wdata = c_req_wdata;
    end else if (l_gnt) begin
      mem_we    = l_req_we;
      mem_addr  = l_req_addr;
      mem_wdata = l_req_wdata;
    end
  end

  always_comb begin
    resp_type_d = resp_type(c_gnt | l_gnt, mem_we);
    win_d       = l_gnt ? PORT_LDR : PORT_CORE;
    rdata_d     = (resp_type_d == RespRead) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_type_q <= RespNone;
      win_q       <= PORT_CORE;
      rdata_q     <= '0;
    end else begin
      resp_type_q <= resp_type_d;
      win_q       <= win_d;
      rdata_q     <= rdata_d;
    end
  end

  assign c_resp_valid = (resp_type_q != RespNone) && (win_q == PORT_CORE);
  assign l_resp_valid = (resp_type_q != RespNone) && (win_q == PORT_LDR);
  assign resp_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a small memory model.
module tb_dmem_arbiter;

  localparam int unsigned Limit = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req_valid, c_req_we, c_req_ready, c_resp_valid;
  logic [31:0] c_req_addr, c_req_wdata;
  logic        l_req_valid, l_req_we, l_req_ready, l_resp_valid;
  logic [31:0] l_req_addr, l_req_wdata;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [64];

  typedef struct {
    logic        c;
    logic        l;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt   = 0;
  logic cg, lg;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(Limit)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c_req_valid (c_req_valid),
    .c_req_we    (c_req_we),
    .c_req_addr  (c_req_addr),
    .c_req_wdata (c_req_wdata),
    .c_req_ready (c_req_ready),
    .c_resp_valid(c_resp_valid),
    .l_req_valid (l_req_valid),
    .l_req_we    (l_req_we),
    .l_req_addr  (l_req_addr),
    .l_req_wdata (l_req_wdata),
    .l_req_ready (l_req_ready),
    .l_resp_valid(l_resp_valid),
    .resp_rdata  (resp_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_none();
    exp_t e;
    e.c = 1'b0; e.l = 1'b0; e.d = '0;
    sb.push_back(e);
  endtask

  // One cycle: drive after the edge, check responses and grant before the next edge.
  task automatic step(input logic cv, input logic cwe, input logic [31:0] ca,
                      input logic [31:0] cd, input logic lv, input logic lwe,
                      input logic [31:0] la, input logic [31:0] ld,
                      output logic cg_o, output logic lg_o);
    exp_t e, n;
    logic [31:0] a;
    logic w;
    @(posedge clk); #1;
    c_req_valid = cv; c_req_we = cwe; c_req_addr = ca; c_req_wdata = cd;
    l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = ld;
    #3;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("c_resp_valid", 32'(c_resp_valid), 32'(e.c));
      chk("l_resp_valid", 32'(l_resp_valid), 32'(e.l));
      if (e.c || e.l) chk("resp_rdata", resp_rdata, e.d);
    end
    lg_o = lv && (!cv || cnt == Limit);
    cg_o = cv && !lg_o;
    if (lg_o || (cv && !lv)) cnt = 0;
    else if (cg_o) cnt++;
    chk("c_req_ready", 32'(c_req_ready), 32'(cg_o));
    chk("l_req_ready", 32'(l_req_ready), 32'(lg_o));
    w = cg_o ? cwe : (lg_o ? lwe : 1'b0);
    a = cg_o ? ca : (lg_o ? la : 32'h0);
    chk("mem_we", 32'(mem_we), 32'(w));
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, cg_o ? cd : (lg_o ? ld : 32'h0));
    n.c = cg_o; n.l = lg_o;
    n.d = ((cg_o || lg_o) && !w) ? mem[a[7:2]] : 32'h0;
    sb.push_back(n);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_c_ready", 32'(c_req_ready), 32'h0);
    chk("rst_l_ready", 32'(l_req_ready), 32'h0);
    chk("rst_c_resp", 32'(c_resp_valid), 32'h0);
    chk("rst_l_resp", 32'(l_resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[16] = 32'h0;
    rst = 1'b0;
    c_req_valid = 1'b1; c_req_we = 1'b1; c_req_addr = 32'h8; c_req_wdata = 32'h5;
    l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 32'hC; l_req_wdata = 32'h6;
    repeat (2) @(posedge clk);
    #4 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    c_req_valid = 1'b0; l_req_valid = 1'b0;
    push_none();

    // Core-only read stream.
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, cg, lg);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0, cg, lg);
    step(1, 0, 32'h8, 0, 0, 0, 0, 0, cg, lg);
    step(0, 0, 0, 0, 0, 0, 0, 0, cg, lg);
    // Loader write then core read-back of the same word.
    step(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, cg, lg);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, cg, lg);
    step(0, 0, 0, 0, 0, 0, 0, 0, cg, lg);
    chk("readback_word", mem[16], 32'hDEADBEEF);

    // Continuous contention: 8 core grants then one loader grant, repeating.
    for (int i = 0; i < 27; i++) begin
      step(1, 0, 32'(i * 4), 0, 1, 1, 32'(128 + (i % 16) * 4), 32'hA000 + 32'(i), cg, lg);
      chk("starve_pattern", 32'(l_req_ready), 32'(i % 9 == 8));
    end

    // Loader drops out after 5 core grants; counter restarts from zero.
    for (int i = 0; i < 5; i++) step(1, 0, 32'(i * 4), 0, 1, 0, 32'h4, 0, cg, lg);
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, cg, lg);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 32'(i * 4), 0, 1, 0, 32'h8, 0, cg, lg);
      chk("restart_pattern", 32'(l_req_ready), 32'(i == 8));
    end

    // Idle cycles hold the counter: 3 core grants, 4 idle, then loader wins after 5 more.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, cg, lg);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, cg, lg);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, cg, lg);
      chk("hold_pattern", 32'(l_req_ready), 32'(i == 5));
    end

    // Reset in the cycle after a read grant drops its response.
    step(1, 0, 32'h8, 0, 0, 0, 0, 0, cg, lg);
    @(posedge clk); #1;
    rst = 1'b0;
    c_req_valid = 1'b1; l_req_valid = 1'b1;
    #3 chk_reset_outputs();
    sb.delete();
    cnt = 0;
    push_none();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    c_req_valid = 1'b0; l_req_valid = 1'b0;
    step(1, 0, 32'h4, 0, 0, 0, 0, 0, cg, lg);
    chk("post_reset_grant", 32'(c_req_ready), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, cg, lg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
